// File: rtl/pwm_bit_decoder.sv
// Pulse-width-coded serial receiver: measures high-pulse and low-gap widths with a
// timed Moore FSM and assembles N_BITS-wide words, MSB first.
module pwm_bit_decoder #(
  parameter int N_BITS    = 8,
  parameter int T_BIT_MIN = 10,
  parameter int T_THRESH  = 40,
  parameter int T_BIT_MAX = 100,
  parameter int T_GAP_MAX = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              err,
  output logic              busy
);

  localparam int T_LIM = (T_BIT_MAX > T_GAP_MAX) ? T_BIT_MAX : T_GAP_MAX;
  localparam int TW    = $clog2(T_LIM + 2);
  localparam int BW    = $clog2(N_BITS + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_MIN_W = TW'(T_BIT_MIN);
  localparam logic [TW-1:0] T_THR_W = TW'(T_THRESH);
  localparam logic [TW-1:0] T_MAX_W = TW'(T_BIT_MAX);
  localparam logic [TW-1:0] T_GAP_W = TW'(T_GAP_MAX);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic [BW-1:0] B_FULL  = BW'(N_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE,
    S_ERR,
    S_RECOVER
  } state_t;

  state_t            state_reg, state_next;
  logic [TW-1:0]     t_reg, t_next, t_inc;
  logic [BW-1:0]     bcnt_reg, bcnt_next, bcnt_inc;
  logic [N_BITS-1:0] shift_reg, shift_next, shift_in, data_next;
  logic              bit_val;

  // Timer saturates rather than wrapping, so a stuck line can never alias a legal width.
  assign t_inc    = (t_reg == '1) ? t_reg : t_reg + T_ONE;
  assign bit_val  = (t_reg >= T_THR_W);
  assign shift_in = (shift_reg << 1) | N_BITS'(bit_val);
  assign bcnt_inc = bcnt_reg + B_ONE;

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    bcnt_next  = bcnt_reg;
    shift_next = shift_reg;
    data_next  = data_out;

    unique case (state_reg)
      S_IDLE: begin
        if (din) begin
          state_next = S_HIGH;
          t_next     = T_ONE;
          bcnt_next  = '0;
          shift_next = '0;
        end
      end

      S_HIGH: begin
        if (din) begin
          if (t_reg == T_MAX_W) state_next = S_ERR;
          else                  t_next     = t_inc;
        end else if (t_reg < T_MIN_W) begin
          state_next = S_ERR;
        end else begin
          shift_next = shift_in;
          bcnt_next  = bcnt_inc;
          if (bcnt_inc == B_FULL) begin
            state_next = S_DONE;
            data_next  = shift_in;
          end else begin
            state_next = S_LOW;
            t_next     = T_ONE;
          end
        end
      end

      S_LOW: begin
        if (din) begin
          state_next = S_HIGH;
          t_next     = T_ONE;
        end else if (t_reg == T_GAP_W) begin
          state_next = S_ERR;
        end else begin
          t_next = t_inc;
        end
      end

      // A rising edge seen during DONE opens the next frame immediately.
      S_DONE: begin
        if (din) begin
          state_next = S_HIGH;
          t_next     = T_ONE;
          bcnt_next  = '0;
          shift_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_ERR: begin
        state_next = S_RECOVER;
        t_next     = T_ONE;
      end

      S_RECOVER: begin
        if (din)                  t_next     = T_ONE;
        else if (t_reg == T_GAP_W) state_next = S_IDLE;
        else                      t_next     = t_inc;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      t_reg      <= '0;
      bcnt_reg   <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      t_reg      <= t_next;
      bcnt_reg   <= bcnt_next;
      shift_reg  <= shift_next;
      data_out   <= data_next;
      data_valid <= (state_next == S_DONE);
      err        <= (state_next == S_ERR);
      busy       <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_bit_decoder.sv
// Self-checking bench for pwm_bit_decoder: run-length reference model checked every
// cycle, plus directed width-boundary table and multi-cycle corner-case sequences.
`timescale 1ns/1ps
module tb_pwm_bit_decoder;

  localparam int N_BITS    = 8;
  localparam int T_BIT_MIN = 10;
  localparam int T_THRESH  = 40;
  localparam int T_BIT_MAX = 100;
  localparam int T_GAP_MAX = 100;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_REC   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              din = 1'b0;
  logic [N_BITS-1:0] data_out;
  logic              data_valid, err, busy;

  pwm_bit_decoder #(
    .N_BITS(N_BITS), .T_BIT_MIN(T_BIT_MIN), .T_THRESH(T_THRESH),
    .T_BIT_MAX(T_BIT_MAX), .T_GAP_MAX(T_GAP_MAX)
  ) dut (
    .clk(clk), .reset(reset), .din(din),
    .data_out(data_out), .data_valid(data_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int width;
    bit exp_err;
    bit exp_bit;
  } width_vec_t;

  width_vec_t vecs[6];

  int n_vec = 0;
  int n_fail = 0;
  int tick = 0;

  // Reference model: tracks run lengths of the line rather than a timer.
  int                m_mode, m_ones, m_zeros, m_nbits;
  bit                m_after_done, m_after_err;
  logic [N_BITS-1:0] m_word;
  logic [N_BITS-1:0] exp_data;
  bit                exp_valid, exp_err, exp_busy;

  // Bench-side event monitors.
  int                valid_cnt, err_cnt, idle_cnt, valid_tick, err_tick;
  logic [N_BITS-1:0] valid_q[$];
  logic [N_BITS-1:0] last_good;

  function automatic void modelReset();
    m_mode = M_IDLE; m_ones = 0; m_zeros = 0; m_nbits = 0;
    m_after_done = 0; m_after_err = 0; m_word = '0;
    exp_data = '0; exp_valid = 0; exp_err = 0; exp_busy = 0;
  endfunction

  function automatic void modelStartFrame();
    m_mode = M_FRAME; m_ones = 1; m_zeros = 0; m_nbits = 0; m_word = '0;
  endfunction

  function automatic void modelError();
    exp_err = 1; m_after_err = 1; m_mode = M_IDLE;
  endfunction

  function automatic void modelStep(input logic d);
    exp_valid = 0;
    exp_err   = 0;
    if (m_after_err) begin
      m_after_err = 0; m_mode = M_REC; m_zeros = 0;
    end else if (m_after_done) begin
      m_after_done = 0;
      if (d) modelStartFrame();
      else   m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (d) modelStartFrame();
        M_FRAME: begin
          if (m_ones > 0) begin
            if (d) begin
              m_ones++;
              if (m_ones > T_BIT_MAX) modelError();
            end else if (m_ones < T_BIT_MIN) begin
              modelError();
            end else begin
              m_word = {m_word[N_BITS-2:0], (m_ones >= T_THRESH)};
              m_nbits++;
              m_ones = 0;
              m_zeros = 1;
              if (m_nbits == N_BITS) begin
                exp_valid = 1; exp_data = m_word; m_after_done = 1; m_mode = M_IDLE;
              end
            end
          end else begin
            if (d) m_ones = 1;
            else begin
              m_zeros++;
              if (m_zeros > T_GAP_MAX) modelError();
            end
          end
        end
        default: begin
          if (d) m_zeros = 0;
          else begin
            m_zeros++;
            if (m_zeros == T_GAP_MAX) m_mode = M_IDLE;
          end
        end
      endcase
    end
    exp_busy = m_after_done || m_after_err || (m_mode != M_IDLE);
  endfunction

  task automatic checkOutput();
    n_vec++;
    if ({data_out, data_valid, err, busy} !== {exp_data, exp_valid, exp_err, exp_busy}) begin
      n_fail++;
      $display("[TB] FAIL cycle_outputs tick %0d: got data=%h valid=%b err=%b busy=%b, want data=%h valid=%b err=%b busy=%b",
               tick, data_out, data_valid, err, busy, exp_data, exp_valid, exp_err, exp_busy);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic clearMon();
    valid_cnt = 0; err_cnt = 0; idle_cnt = 0; valid_tick = -1; err_tick = -1;
    valid_q.delete();
  endtask

  task automatic applyStimulus(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din = level;
      @(posedge clk);
      modelStep(level);
      #1;
      tick++;
      checkOutput();
      if (data_valid) begin
        valid_cnt++; valid_tick = tick; valid_q.push_back(data_out);
      end
      if (err) begin
        err_cnt++; err_tick = tick;
      end
      if (!busy) idle_cnt++;
    end
  endtask

  task automatic sendBits(input logic [N_BITS-1:0] word, input int first, input int nb,
                          input int w1, input int w0, input int gap, input int trail);
    for (int i = 0; i < nb; i++) begin
      applyStimulus(1'b1, word[first-i] ? w1 : w0);
      if (i < nb - 1)     applyStimulus(1'b0, gap);
      else if (trail > 0) applyStimulus(1'b0, trail);
    end
  endtask

  task automatic sendFrame(input logic [N_BITS-1:0] word, input int trail);
    sendBits(word, N_BITS - 1, N_BITS, 50, 20, 20, trail);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, exp_tick, w, gap;
    logic [N_BITS-1:0] expw;

    vecs[0] = '{width: 9,   exp_err: 1, exp_bit: 0};
    vecs[1] = '{width: 10,  exp_err: 0, exp_bit: 0};
    vecs[2] = '{width: 39,  exp_err: 0, exp_bit: 0};
    vecs[3] = '{width: 40,  exp_err: 0, exp_bit: 1};
    vecs[4] = '{width: 100, exp_err: 0, exp_bit: 1};
    vecs[5] = '{width: 101, exp_err: 1, exp_bit: 0};

    modelReset();
    #1 reset = 1'b1;
    #2;
    checkValue("reset_state", int'({data_out, data_valid, err, busy}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Nominal frame 0xA5
    clearMon();
    applyStimulus(1'b0, 5);
    sendFrame(8'hA5, 0);
    exp_tick = tick + 1;
    applyStimulus(1'b0, 20);
    checkValue("nominal_valid_count", valid_cnt, 1);
    checkValue("nominal_valid_tick", valid_tick, exp_tick);
    checkValue("nominal_data", int'(valid_q.size() > 0 ? valid_q[0] : 8'h00), 8'hA5);
    checkValue("nominal_err_count", err_cnt, 0);
    last_good = 8'hA5;

    // Width boundaries on the first bit of a frame
    for (int k = 0; k < 6; k++) begin
      clearMon();
      t0 = tick;
      applyStimulus(1'b1, vecs[k].width);
      if (vecs[k].exp_err) begin
        applyStimulus(1'b0, 110);
        exp_tick = (vecs[k].width > T_BIT_MAX) ? t0 + T_BIT_MAX + 1 : t0 + vecs[k].width + 1;
        checkValue($sformatf("w%0d_err_count", vecs[k].width), err_cnt, 1);
        checkValue($sformatf("w%0d_err_tick", vecs[k].width), err_tick, exp_tick);
        checkValue($sformatf("w%0d_valid_count", vecs[k].width), valid_cnt, 0);
        checkValue($sformatf("w%0d_data_hold", vecs[k].width), int'(data_out), int'(last_good));
      end else begin
        applyStimulus(1'b0, 20);
        sendBits(8'h5A, 6, 7, 50, 20, 20, 10);
        expw = {vecs[k].exp_bit, 7'h5A};
        checkValue($sformatf("w%0d_valid_count", vecs[k].width), valid_cnt, 1);
        checkValue($sformatf("w%0d_data", vecs[k].width), int'(data_out), int'(expw));
        checkValue($sformatf("w%0d_err_count", vecs[k].width), err_cnt, 0);
        last_good = expw;
      end
    end

    // Gap timeout after three bits, then recovery and frame 0x3C
    clearMon();
    sendBits(8'hA0, 7, 3, 50, 20, 20, 0);
    applyStimulus(1'b0, 101);
    checkValue("gap_err_count", err_cnt, 1);
    checkValue("gap_err_tick", err_tick, tick);
    clearMon();
    applyStimulus(1'b0, 100);
    checkValue("gap_busy_in_recover", idle_cnt, 0);
    applyStimulus(1'b0, 1);
    checkValue("gap_back_to_idle", idle_cnt, 1);
    clearMon();
    sendFrame(8'h3C, 10);
    checkValue("gap_next_valid_count", valid_cnt, 1);
    checkValue("gap_next_data", int'(data_out), 8'h3C);
    checkValue("gap_next_err_count", err_cnt, 0);

    // Long glitch, recovery, then 0xFF
    clearMon();
    applyStimulus(1'b1, 120);
    applyStimulus(1'b0, 100);
    sendFrame(8'hFF, 10);
    checkValue("glitch_err_count", err_cnt, 1);
    checkValue("glitch_valid_count", valid_cnt, 1);
    checkValue("glitch_data", int'(data_out), 8'hFF);

    // Back-to-back frames, second frame starting in the DONE cycle
    clearMon();
    sendFrame(8'h01, 1);
    sendFrame(8'h80, 10);
    checkValue("b2b_valid_count", valid_cnt, 2);
    checkValue("b2b_first", int'(valid_q.size() > 0 ? valid_q[0] : 8'h00), 8'h01);
    checkValue("b2b_second", int'(valid_q.size() > 1 ? valid_q[1] : 8'h00), 8'h80);
    checkValue("b2b_err_count", err_cnt, 0);

    // Asynchronous reset in the middle of a frame
    sendBits(8'hF0, 7, 4, 50, 20, 20, 10);
    @(negedge clk);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkValue("midreset_outputs", int'({data_out, data_valid, err, busy}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    clearMon();
    sendFrame(8'h5A, 10);
    checkValue("midreset_valid_count", valid_cnt, 1);
    checkValue("midreset_data", int'(data_out), 8'h5A);
    checkValue("midreset_err_count", err_cnt, 0);

    // Randomized frames with occasional illegal widths and gaps
    for (int f = 0; f < 25; f++) begin
      for (int b = 0; b < N_BITS; b++) begin
        w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 120))
                                        : int'($urandom_range(T_BIT_MIN, T_BIT_MAX));
        applyStimulus(1'b1, w);
        gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 115))
                                          : int'($urandom_range(1, 40));
        applyStimulus(1'b0, gap);
      end
      applyStimulus(1'b0, int'($urandom_range(1, 20)));
    end
    applyStimulus(1'b0, 120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
